// File: rtl/alu_cmd_sequencer_if.sv
// Handshake bundle of the ALU command sequencer: command bytes in, ALU operands/result,
// and the transmit byte path. The sequencer sits on the slave side.
interface alu_cmd_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic [DATA_WIDTH-1:0] ALU_OUT;
  logic                  ALU_OUT_VALID;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] ALU_A;
  logic [DATA_WIDTH-1:0] ALU_B;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  ALU_EN;
  logic                  CLK_GATE_EN;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  ERR;

  modport master (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, ERR
  );

  modport slave (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, ERR
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command sequencer: collects operands/function, fires the ALU once,
// waits (bounded) for the result and hands it to the transmitter.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic               CLK,
  input  logic               RST,
  alu_cmd_sequencer_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] CMD_AB   = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN  = DATA_WIDTH'(8'hDD);
  localparam logic [CW-1:0]         CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_OUT, SEND
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] alu_a, alu_a_nxt, alu_b, alu_b_nxt;
  logic [DATA_WIDTH-1:0] result, result_nxt, tx_data, tx_data_nxt;
  logic [FUN_WIDTH-1:0]  alu_fun, alu_fun_nxt;
  logic                  alu_en, alu_en_nxt, cg_en, cg_en_nxt;
  logic                  tx_vld, tx_vld_nxt, err, err_nxt;
  logic                  timeout;

  // cnt holds the number of WAIT_OUT cycles already spent before this one
  assign timeout = (cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.RX_D_VLD) begin
        if (bus.RX_P_DATA == CMD_AB)       state_nxt = GET_A;
        else if (bus.RX_P_DATA == CMD_FUN) state_nxt = GET_FUN;
      end
      GET_A:    if (bus.RX_D_VLD) state_nxt = GET_B;
      GET_B:    if (bus.RX_D_VLD) state_nxt = GET_FUN;
      GET_FUN:  if (bus.RX_D_VLD) state_nxt = EXEC;
      EXEC:     state_nxt = WAIT_OUT;
      WAIT_OUT: if (bus.ALU_OUT_VALID) state_nxt = SEND;
                else if (timeout)      state_nxt = IDLE;
      SEND:     if (!bus.TX_BUSY) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Registered outputs are computed from state_nxt so they line up with the state they describe
  always_comb begin
    alu_a_nxt   = alu_a;
    alu_b_nxt   = alu_b;
    alu_fun_nxt = alu_fun;
    result_nxt  = result;
    tx_data_nxt = tx_data;
    tx_vld_nxt  = 1'b0;
    err_nxt     = 1'b0;
    alu_en_nxt  = (state_nxt == EXEC);
    cg_en_nxt   = (state_nxt == EXEC) || (state_nxt == WAIT_OUT);
    cnt_nxt     = '0;
    if (state == WAIT_OUT && state_nxt == WAIT_OUT) cnt_nxt = cnt + 1'b1;
    case (state)
      IDLE:     err_nxt = bus.RX_D_VLD && (bus.RX_P_DATA != CMD_AB) &&
                          (bus.RX_P_DATA != CMD_FUN);
      GET_A:    if (bus.RX_D_VLD) alu_a_nxt = bus.RX_P_DATA;
      GET_B:    if (bus.RX_D_VLD) alu_b_nxt = bus.RX_P_DATA;
      GET_FUN:  if (bus.RX_D_VLD) alu_fun_nxt = bus.RX_P_DATA[FUN_WIDTH-1:0];
      WAIT_OUT: if (bus.ALU_OUT_VALID) result_nxt = bus.ALU_OUT;
                else if (timeout)      err_nxt = 1'b1;
      SEND: if (!bus.TX_BUSY) begin
        tx_vld_nxt  = 1'b1;
        tx_data_nxt = result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt     <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_fun <= '0;
      result  <= '0;
      tx_data <= '0;
      alu_en  <= 1'b0;
      cg_en   <= 1'b0;
      tx_vld  <= 1'b0;
      err     <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      alu_a   <= alu_a_nxt;
      alu_b   <= alu_b_nxt;
      alu_fun <= alu_fun_nxt;
      result  <= result_nxt;
      tx_data <= tx_data_nxt;
      alu_en  <= alu_en_nxt;
      cg_en   <= cg_en_nxt;
      tx_vld  <= tx_vld_nxt;
      err     <= err_nxt;
    end
  end

  assign bus.ALU_A       = alu_a;
  assign bus.ALU_B       = alu_b;
  assign bus.ALU_FUN     = alu_fun;
  assign bus.ALU_EN      = alu_en;
  assign bus.CLK_GATE_EN = cg_en;
  assign bus.TX_P_DATA   = tx_data;
  assign bus.TX_D_VLD    = tx_vld;
  assign bus.ERR         = err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: each command scenario writes a per-cycle expected timeline from the
// command-level timing rules, and a negedge process compares every output against it.
module tb_alu_cmd_sequencer;
  localparam int DW  = 8;
  localparam int FW  = 4;
  localparam int TMO = 15;
  localparam int N   = 512;

  logic CLK, RST;
  int   cyc = 0;
  int   nvec = 0, nerr = 0;

  bit [7:0] e_a [N];
  bit [7:0] e_b [N];
  bit [7:0] e_fun [N];
  bit [7:0] e_txd [N];
  bit       e_en [N];
  bit       e_cg [N];
  bit       e_txv [N];
  bit       e_err [N];

  alu_cmd_sequencer_if #(.DATA_WIDTH(DW), .FUN_WIDTH(FW)) bus ();

  alu_cmd_sequencer #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .TIMEOUT(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (cyc < N) begin
      chk("alu_a",   bus.ALU_A,            e_a[cyc]);
      chk("alu_b",   bus.ALU_B,            e_b[cyc]);
      chk("alu_fun", 8'(bus.ALU_FUN),      e_fun[cyc]);
      chk("tx_data", bus.TX_P_DATA,        e_txd[cyc]);
      chk("alu_en",  8'(bus.ALU_EN),       8'(e_en[cyc]));
      chk("cg_en",   8'(bus.CLK_GATE_EN),  8'(e_cg[cyc]));
      chk("tx_vld",  8'(bus.TX_D_VLD),     8'(e_txv[cyc]));
      chk("err",     8'(bus.ERR),          8'(e_err[cyc]));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.RX_D_VLD      = 1'b0;
    bus.RX_P_DATA     = '0;
    bus.ALU_OUT_VALID = 1'b0;
    bus.ALU_OUT       = 8'hEE;
    bus.TX_BUSY       = 1'b0;
  endtask

  // Registered value visible from cycle c onward (0=A, 1=B, 2=FUN, 3=TX data)
  task automatic hold(input int sel, input int c, input bit [7:0] v);
    for (int i = c; i < N; i++)
      case (sel)
        0:       e_a[i]   = v;
        1:       e_b[i]   = v;
        2:       e_fun[i] = v;
        default: e_txd[i] = v;
      endcase
  endtask

  // Bytes go out every gap+1 cycles from now; ALU answers lat cycles after WAIT_OUT
  // entry (lat<0: never); transmitter busy for `busy` cycles once the result is ready.
  task automatic run_cmd(input bit full, input bit [7:0] a, input bit [7:0] b,
                         input bit [7:0] f, input bit [7:0] res, input int lat,
                         input int busy, input int gap, input bit noise);
    int t, nb, lb, e, w, s, fin;
    bit [7:0] byt [4];
    t = cyc;
    s = 0;
    byt = '{default: 8'h00};
    if (full) begin
      byt[0] = 8'hCC; byt[1] = a; byt[2] = b; byt[3] = f; nb = 4;
    end else begin
      byt[0] = 8'hDD; byt[1] = f; nb = 2;
    end
    lb = t + (nb - 1) * (gap + 1);
    if (full) begin
      hold(0, t + (gap + 1) + 1, a);
      hold(1, t + 2 * (gap + 1) + 1, b);
    end
    hold(2, lb + 1, {4'h0, f[3:0]});
    e = lb + 1;
    w = e + 1;
    e_en[e] = 1'b1;
    if (lat >= 0) begin
      s = w + lat + 1;
      fin = s + busy + 1;
      for (int i = e; i <= w + lat; i++) e_cg[i] = 1'b1;
      e_txv[fin] = 1'b1;
      hold(3, fin, res);
    end else begin
      for (int i = e; i < w + TMO; i++) e_cg[i] = 1'b1;
      e_err[w + TMO] = 1'b1;
      fin = w + TMO;
    end
    while (cyc < fin) begin
      idle_inputs();
      for (int k = 0; k < nb; k++)
        if (cyc == t + k * (gap + 1)) begin
          bus.RX_D_VLD  = 1'b1;
          bus.RX_P_DATA = byt[k];
        end
      if (lat >= 0 && cyc == w + lat) begin
        bus.ALU_OUT_VALID = 1'b1;
        bus.ALU_OUT       = res;
      end
      if (lat >= 0 && cyc >= s && cyc < s + busy) bus.TX_BUSY = 1'b1;
      if (noise && cyc == e) begin
        bus.ALU_OUT_VALID = 1'b1;
        bus.ALU_OUT       = 8'h99;
      end
      if (noise && cyc == w) begin
        bus.RX_D_VLD  = 1'b1;
        bus.RX_P_DATA = 8'h7E;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    int t;
    RST = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst_a",   bus.ALU_A, 8'h00);
    chk("rst_txd", bus.TX_P_DATA, 8'h00);
    chk("rst_err", 8'(bus.ERR), 8'h00);
    RST = 1'b1;
    tick();

    // CC,05,03,00; result 08 two cycles after ALU_EN
    run_cmd(1'b1, 8'h05, 8'h03, 8'h00, 8'h08, 1, 0, 0, 1'b0);
    chk("c1_txv", 8'(bus.TX_D_VLD), 8'h01);
    chk("c1_txd", bus.TX_P_DATA, 8'h08);
    chk("c1_a",   bus.ALU_A, 8'h05);
    chk("c1_b",   bus.ALU_B, 8'h03);

    // DD,01 issued back-to-back, operands reused
    run_cmd(1'b0, 8'h00, 8'h00, 8'h01, 8'h02, 1, 0, 0, 1'b0);
    chk("c2_a",   bus.ALU_A, 8'h05);
    chk("c2_b",   bus.ALU_B, 8'h03);
    chk("c2_fun", 8'(bus.ALU_FUN), 8'h01);
    chk("c2_txd", bus.TX_P_DATA, 8'h02);

    // unknown command byte, with a stray ALU_OUT_VALID in IDLE
    t = cyc;
    e_err[t + 1] = 1'b1;
    bus.RX_D_VLD = 1'b1; bus.RX_P_DATA = 8'h7E;
    bus.ALU_OUT_VALID = 1'b1; bus.ALU_OUT = 8'h55;
    tick();
    idle_inputs();
    chk("bad_err", 8'(bus.ERR), 8'h01);
    tick();

    // ALU never answers; upper function bits are dropped
    run_cmd(1'b1, 8'h11, 8'h22, 8'hF3, 8'h00, -1, 0, 0, 1'b0);
    chk("to_err", 8'(bus.ERR), 8'h01);
    chk("to_cg",  8'(bus.CLK_GATE_EN), 8'h00);
    chk("to_fun", 8'(bus.ALU_FUN), 8'h03);
    chk("to_txd", bus.TX_P_DATA, 8'h02);

    // transmitter busy for 10 cycles; ignored RX/ALU strobes along the way
    run_cmd(1'b1, 8'hA0, 8'h0B, 8'h05, 8'h5A, 0, 10, 0, 1'b1);
    chk("bz_txv", 8'(bus.TX_D_VLD), 8'h01);
    chk("bz_txd", bus.TX_P_DATA, 8'h5A);

    // bytes spaced by idle cycles, slow ALU
    run_cmd(1'b1, 8'h07, 8'h09, 8'h02, 8'h10, 3, 0, 2, 1'b0);
    chk("gp_txd", bus.TX_P_DATA, 8'h10);

    // reset in the middle of a command
    t = cyc;
    bus.RX_D_VLD = 1'b1; bus.RX_P_DATA = 8'hCC;
    tick();
    bus.RX_P_DATA = 8'h05;
    tick();
    idle_inputs();
    chk("mid_a", bus.ALU_A, 8'h05);
    for (int s = 0; s < 4; s++) hold(s, t + 2, 8'h00);
    RST = 1'b0;
    #1;
    chk("mr_a",   bus.ALU_A, 8'h00);
    chk("mr_b",   bus.ALU_B, 8'h00);
    chk("mr_fun", 8'(bus.ALU_FUN), 8'h00);
    chk("mr_txd", bus.TX_P_DATA, 8'h00);
    tick();
    RST = 1'b1;
    bus.RX_D_VLD = 1'b1; bus.RX_P_DATA = 8'h03;
    e_err[cyc + 1] = 1'b1;
    tick();
    idle_inputs();
    chk("mr_err", 8'(bus.ERR), 8'h01);
    tick();

    // fresh command after reset
    run_cmd(1'b1, 8'h0F, 8'h01, 8'h02, 8'h10, 2, 0, 0, 1'b0);
    chk("pr_txv", 8'(bus.TX_D_VLD), 8'h01);
    chk("pr_a",   bus.ALU_A, 8'h0F);

    for (int i = 0; i < 4; i++) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning operand/result/byte width.
REQ-002 The block SHALL have parameter FUN_WIDTH, default 4, meaning ALU function code width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning max cycles waited for ALU result.
REQ-004 The block SHALL have port CLK, input, 1, system clock.
REQ-005 The block SHALL have port RST, input, 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port RX_P_DATA, input, DATA_WIDTH, received command/operand byte.
REQ-007 The block SHALL have port RX_D_VLD, input, 1, RX_P_DATA valid for one cycle.
REQ-008 The block SHALL have port ALU_OUT, input, DATA_WIDTH, ALU result.
REQ-009 The block SHALL have port ALU_OUT_VALID, input, 1, ALU result valid.
REQ-010 The block SHALL have port TX_BUSY, input, 1, transmitter cannot accept data.
REQ-011 The block SHALL have port ALU_A, output, DATA_WIDTH, operand A register.
REQ-012 The block SHALL have port ALU_B, output, DATA_WIDTH, operand B register.
REQ-013 The block SHALL have port ALU_FUN, output, FUN_WIDTH, function code register.
REQ-014 The block SHALL have port ALU_EN, output, 1, ALU operation enable.
REQ-015 The block SHALL have port CLK_GATE_EN, output, 1, ALU clock-gate enable.
REQ-016 The block SHALL have port TX_P_DATA, output, DATA_WIDTH, result byte to transmitter.
REQ-017 The block SHALL have port TX_D_VLD, output, 1, TX_P_DATA valid, one-cycle pulse.
REQ-018 The block SHALL have port ERR, output, 1, one-cycle error pulse.

Function
REQ-019 The FSM SHALL have states IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_OUT, SEND; all outputs registered.
REQ-020 IDLE: RX_D_VLD with 0xCC -> GET_A; 0xDD -> GET_FUN; any other byte -> stay IDLE, ERR pulse next cycle.
REQ-021 GET_A/GET_B/GET_FUN: on RX_D_VLD capture RX_P_DATA into ALU_A / ALU_B / ALU_FUN (low FUN_WIDTH bits), advance GET_A->GET_B->GET_FUN->EXEC; without RX_D_VLD hold state.
REQ-022 0xDD path SHALL reuse last captured ALU_A/ALU_B unchanged.
REQ-023 EXEC: ALU_EN=1 for exactly one cycle, CLK_GATE_EN=1; next state WAIT_OUT.
REQ-024 CLK_GATE_EN SHALL be 1 in cycles when state is EXEC or WAIT_OUT and 0 otherwise.
REQ-025 WAIT_OUT: on ALU_OUT_VALID capture ALU_OUT into result register, go SEND; ALU_EN=0.
REQ-026 WAIT_OUT counter SHALL count cycles from entry; when count reaches TIMEOUT without ALU_OUT_VALID -> IDLE with ERR pulse, result not sent.
REQ-027 SEND: while TX_BUSY=1 hold; when TX_BUSY=0 drive TX_P_DATA=result, TX_D_VLD=1 one cycle, then IDLE.
REQ-028 RX_D_VLD in EXEC, WAIT_OUT, SEND SHALL be ignored (byte dropped, no ERR).
REQ-029 ALU_OUT_VALID outside WAIT_OUT SHALL be ignored.
REQ-030 TX_P_DATA SHALL hold its last sent value when TX_D_VLD=0.
REQ-031 Throughput: back-to-back commands allowed; first command byte accepted in the cycle after SEND completes.

Reset
REQ-032 RST low SHALL asynchronously force state IDLE, counter 0, ALU_A/ALU_B/ALU_FUN/TX_P_DATA/result = 0, ALU_EN/CLK_GATE_EN/TX_D_VLD/ERR = 0.
REQ-033 Reset asserted mid-command SHALL abandon the command; no TX_D_VLD after release until a new complete command.

Verification
REQ-034 Bytes 0xCC,0x05,0x03,0x00 with ALU returning 0x08 after 2 cycles, TX_BUSY=0 -> ALU_A=0x05, ALU_B=0x03, ALU_FUN=0x0, one ALU_EN pulse, TX_P_DATA=0x08 with one TX_D_VLD pulse.
REQ-035 Then 0xDD,0x01 with ALU returning 0x02 -> ALU_A/ALU_B stay 0x05/0x03, ALU_FUN=0x1, TX_P_DATA=0x02.
REQ-036 Byte 0x7E in IDLE -> single ERR pulse, state stays IDLE, no ALU_EN.
REQ-037 Full 0xCC command, ALU_OUT_VALID never asserted -> ERR pulse 15 cycles after WAIT_OUT entry, CLK_GATE_EN drops, no TX_D_VLD.
REQ-038 Result ready with TX_BUSY=1 for 10 cycles -> TX_D_VLD asserted only in cycle after TX_BUSY falls, data unchanged.
REQ-039 RST low after 0xCC,0x05 -> all outputs 0 immediately; following 0x03 byte -> ERR pulse (treated as unknown command).
